fifo_wr_ctrl_g2: RTL and testbench

Second-generation write-side controller for the async FIFO: owns the write pointer, produces registered full/almost-full/programmable-full flags, a registered fill count, overflow and write-acknowledge status, and a Gray-coded pointer ready for synchronisation into the read domain. It sits between the user write port and the dual-port RAM. It takes the read pointer already Gray-synchronised into `wr_clk`, and supports write-side width ratios through `WR_IND`.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_gray2bin.sv | 16 +
 rtl/fifo_wr_ctrl_g2.sv | 88 ++++++++
 tb/tb_fifo_wr_ctrl_g2.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO controllers: Gray/binary conversion,
// a constant-foldable clog2 and the write-count width derivation.
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // One count bit per address bit plus the wrap bit, less the bits a wide write consumes.
  function automatic int wr_cnt_width(input int ram_addr_width, input int wr_ind);
    return ram_addr_width + 1 - clog2(wr_ind);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above it. Shared by the write and read controllers.
module fifo_gray2bin #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_ctrl_g2.sv
// Write-side controller of the async FIFO: pointer, registered flags and count.
// Optional programmable-full flag enabled by defining FIFO_WR_PROG_FULL_EN.
module fifo_wr_ctrl_g2
  import fifo_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH  = 5,
  parameter int WR_IND          = 1,
  parameter int WR_CNT_WIDTH    = wr_cnt_width(RAM_ADDR_WIDTH, WR_IND),
  parameter int ALMOST_FULL_GAP = 1
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst_n,
  input  logic                      wr_en,
  input  logic [RAM_ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic [RAM_ADDR_WIDTH:0]   wr_ptr_bin,
  output logic [RAM_ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                      ram_wr_en,
  output logic                      fifo_full,
  output logic                      almost_full,
  output logic                      wr_ack,
  output logic                      overflow,
  output logic [WR_CNT_WIDTH-1:0]   wr_data_count
`ifdef FIFO_WR_PROG_FULL_EN
  ,
  input  logic [WR_CNT_WIDTH-1:0]   prog_full_thresh,
  output logic                      prog_full
`endif
);

  localparam int PW       = RAM_ADDR_WIDTH + 1;
  localparam int DEPTH    = 1 << RAM_ADDR_WIDTH;
  localparam int IND_SH   = clog2(WR_IND);
  localparam int SLOT_CNT = DEPTH / WR_IND;

  logic [PW-1:0]           rd_bin;
  logic [PW-1:0]           wr_ptr_next;
  logic [PW-1:0]           cnt_next;
  logic [PW-1:0]           free_words;
  logic [WR_CNT_WIDTH-1:0] slots;
  logic [WR_CNT_WIDTH-1:0] free_slots;
  logic                    full_next;
  logic                    almost_full_next;

  fifo_gray2bin #(.WIDTH(PW)) u_rd_gray2bin (
    .gray (rd_ptr_gray_sync),
    .bin  (rd_bin)
  );

  assign ram_wr_en = wr_en & ~fifo_full;

  // Occupancy spans 0..DEPTH, so a plain modular difference covers the wrap case.
  always_comb begin
    wr_ptr_next      = wr_ptr_bin + (ram_wr_en ? PW'(WR_IND) : PW'(0));
    cnt_next         = wr_ptr_next - rd_bin;
    slots            = WR_CNT_WIDTH'(cnt_next >> IND_SH);
    free_words       = PW'(DEPTH) - cnt_next;
    free_slots       = WR_CNT_WIDTH'(SLOT_CNT) - slots;
    full_next        = free_words < PW'(WR_IND);
    almost_full_next = free_slots <= WR_CNT_WIDTH'(ALMOST_FULL_GAP);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_bin    <= '0;
      wr_ptr_gray   <= '0;
      wr_data_count <= '0;
      fifo_full     <= 1'b0;
      almost_full   <= 1'b0;
      wr_ack        <= 1'b0;
      overflow      <= 1'b0;
`ifdef FIFO_WR_PROG_FULL_EN
      prog_full     <= 1'b0;
`endif
    end else begin
      wr_ptr_bin    <= wr_ptr_next;
      wr_ptr_gray   <= PW'(bin2gray(32'(wr_ptr_next)));
      wr_data_count <= slots;
      fifo_full     <= full_next;
      almost_full   <= almost_full_next;
      wr_ack        <= ram_wr_en;
      overflow      <= wr_en & fifo_full;
`ifdef FIFO_WR_PROG_FULL_EN
      prog_full     <= slots >= prog_full_thresh;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl_g2.sv
// Bench for fifo_wr_ctrl_g2: word-count model checked every cycle on a
// depth-32 single-word instance, plus directed checks on a WR_IND=2 instance.
module tb_fifo_wr_ctrl_g2;

  logic       clk = 1'b0;
  logic       wr_rst_n;
  logic       wr_en, wr_en2;
  int         rd_words;
  logic [5:0] rd_gray, rd_gray2;

  logic [5:0] wr_ptr_bin, wr_ptr_gray, ptr2, gray2;
  logic       ram_wr_en, fifo_full, almost_full, wr_ack, overflow;
  logic       ram_wr_en2, full2, af2, ack2, ovf2;
  logic [5:0] wr_data_count;
  logic [4:0] cnt2;
`ifdef FIFO_WR_PROG_FULL_EN
  logic       prog_full, pf2;
  logic [5:0] pf_thresh = 6'd10;
  logic [4:0] pf_thresh2 = 5'd8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] gray_of(input int b);
    logic [5:0] v;
    v = b[5:0];
    return v ^ (v >> 1);
  endfunction

  assign rd_gray  = gray_of(rd_words);
  assign rd_gray2 = 6'd0;

  fifo_wr_ctrl_g2 #(.RAM_ADDR_WIDTH(5), .WR_IND(1), .ALMOST_FULL_GAP(1)) dut (
    .wr_clk(clk), .wr_rst_n(wr_rst_n), .wr_en(wr_en), .rd_ptr_gray_sync(rd_gray),
    .wr_ptr_bin(wr_ptr_bin), .wr_ptr_gray(wr_ptr_gray), .ram_wr_en(ram_wr_en),
    .fifo_full(fifo_full), .almost_full(almost_full), .wr_ack(wr_ack),
    .overflow(overflow), .wr_data_count(wr_data_count)
`ifdef FIFO_WR_PROG_FULL_EN
    , .prog_full_thresh(pf_thresh), .prog_full(prog_full)
`endif
  );

  fifo_wr_ctrl_g2 #(.RAM_ADDR_WIDTH(5), .WR_IND(2), .ALMOST_FULL_GAP(1)) dut2 (
    .wr_clk(clk), .wr_rst_n(wr_rst_n), .wr_en(wr_en2), .rd_ptr_gray_sync(rd_gray2),
    .wr_ptr_bin(ptr2), .wr_ptr_gray(gray2), .ram_wr_en(ram_wr_en2),
    .fifo_full(full2), .almost_full(af2), .wr_ack(ack2),
    .overflow(ovf2), .wr_data_count(cnt2)
`ifdef FIFO_WR_PROG_FULL_EN
    , .prog_full_thresh(pf_thresh2), .prog_full(pf2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: total words written/read as plain integers; occupancy is their difference.
  int m_wr, m_occ, nw, occ;
  bit m_full, m_af, m_ack, m_ovf, m_pf;

  always @(posedge clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      m_wr <= 0; m_occ <= 0; m_full <= 0; m_af <= 0; m_ack <= 0; m_ovf <= 0; m_pf <= 0;
    end else begin
      nw  = m_wr + ((wr_en && !m_full) ? 1 : 0);
      occ = nw - rd_words;
      if (occ < 0 || occ > 32) begin
        errors++;
        $display("FAIL illegal_rd: occupancy %0d outside 0..32", occ);
      end
      m_ack  <= wr_en && !m_full;
      m_ovf  <= wr_en && m_full;
      m_wr   <= nw;
      m_occ  <= occ;
      m_full <= (32 - occ) < 1;
      m_af   <= (32 - occ) <= 1;
      m_pf   <= occ >= 10;
    end
  end

  logic [5:0] prev_ptr, prev_gray;
  always @(posedge clk) begin
    #1;
    if (wr_rst_n) begin
      chk("m_ptr", wr_ptr_bin, m_wr % 64);
      chk("m_gray", wr_ptr_gray, gray_of(m_wr));
      chk("m_count", wr_data_count, m_occ);
      chk("m_full", fifo_full, m_full);
      chk("m_almost_full", almost_full, m_af);
      chk("m_wr_ack", wr_ack, m_ack);
      chk("m_overflow", overflow, m_ovf);
      chk("m_ram_wr_en", ram_wr_en, wr_en && !m_full);
`ifdef FIFO_WR_PROG_FULL_EN
      chk("m_prog_full", prog_full, m_pf);
`endif
      if (wr_ptr_bin == prev_ptr + 6'd1)
        chk("gray_one_bit", $countones(wr_ptr_gray ^ prev_gray), 1);
    end
    prev_ptr  = wr_ptr_bin;
    prev_gray = wr_ptr_gray;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int toggles;
  logic prev_msb;

  initial begin
    wr_rst_n = 1'b0; wr_en = 1'b0; wr_en2 = 1'b0; rd_words = 0;
    repeat (3) @(negedge clk);
    chk("rst_ptr", wr_ptr_bin, 0);
    chk("rst_count", wr_data_count, 0);
    chk("rst_full", fifo_full, 0);
    @(negedge clk) wr_rst_n = 1'b1;

    for (int k = 1; k <= 32; k++) begin
      @(negedge clk) wr_en = 1'b1;
      @(posedge clk); #1;
      chk("fill_count", wr_data_count, k);
      chk("fill_af", almost_full, (k >= 31) ? 1 : 0);
      chk("fill_full", fifo_full, (k == 32) ? 1 : 0);
`ifdef FIFO_WR_PROG_FULL_EN
      chk("fill_pf", prog_full, (k >= 10) ? 1 : 0);
`endif
    end
    @(posedge clk); #1;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_ack", wr_ack, 0);
    chk("ovf_ptr", wr_ptr_bin, 32);

    @(negedge clk) begin wr_en = 1'b0; rd_words = 1; end
    @(posedge clk); #1;
    chk("drain_full", fifo_full, 0);
    chk("drain_count", wr_data_count, 31);
    @(negedge clk) wr_en = 1'b1;
    #1 chk("refill_ram_wr_en", ram_wr_en, 1);
    @(posedge clk); #1;
    chk("refill_count", wr_data_count, 32);
    chk("refill_ptr", wr_ptr_bin, 33);
    chk("refill_full", fifo_full, 1);

    @(negedge clk) begin wr_en = 1'b0; rd_words = 30; end
    @(posedge clk); #1;
    chk("wrap_start_count", wr_data_count, 3);
    toggles = 0;
    prev_msb = wr_ptr_bin[5];
    for (int i = 0; i < 100; i++) begin
      @(negedge clk) begin wr_en = 1'b1; rd_words++; end
      @(posedge clk); #1;
      chk("wrap_count", wr_data_count, 3);
      if (wr_ptr_bin[5] != prev_msb) toggles++;
      prev_msb = wr_ptr_bin[5];
    end
    chk("wrap_ptr", wr_ptr_bin, 5);
    chk("wrap_msb_toggles", toggles, 3);

    @(negedge clk) wr_en = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk) wr_en2 = 1'b1;
      @(posedge clk); #1;
      chk("w2_count", cnt2, k);
      chk("w2_ptr", ptr2, 2 * k);
      chk("w2_full", full2, (k == 16) ? 1 : 0);
      chk("w2_af", af2, (k >= 15) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("w2_ovf", ovf2, 1);
    chk("w2_ptr_hold", ptr2, 32);
    @(negedge clk) wr_en2 = 1'b0;

    for (int k = 0; k < 17; k++) begin
      @(negedge clk) wr_en = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_reset_count", wr_data_count, 20);
    @(negedge clk); #2;
    wr_rst_n = 1'b0; rd_words = 0; wr_en = 1'b0;
    #1;
    chk("async_ptr", wr_ptr_bin, 0);
    chk("async_gray", wr_ptr_gray, 0);
    chk("async_count", wr_data_count, 0);
    chk("async_full", fifo_full, 0);
    chk("async_af", almost_full, 0);
    chk("async_ack", wr_ack, 0);
    chk("async_ovf", overflow, 0);
    chk("async_w2_ptr", ptr2, 0);
    chk("async_w2_full", full2, 0);
    @(negedge clk) wr_rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk) wr_en = 1'b1;
      @(posedge clk); #1;
    end
    chk("pf_count10", wr_data_count, 10);
`ifdef FIFO_WR_PROG_FULL_EN
    chk("pf_high", prog_full, 1);
`endif
    @(negedge clk) begin wr_en = 1'b0; rd_words = 1; end
    @(posedge clk); #1;
    chk("pf_count9", wr_data_count, 9);
`ifdef FIFO_WR_PROG_FULL_EN
    chk("pf_low", prog_full, 0);
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
